// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 port arbiter family: FSM states, op encoding and
// the round-robin pointer width helper.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_e;

  localparam int RR_PTR_W_MIN = 1;

  // Pointer width for n requesters; never narrower than one bit.
  function automatic int rr_ptr_width(input int n);
    return ($clog2(n) > RR_PTR_W_MIN) ? $clog2(n) : RR_PTR_W_MIN;
  endfunction

endpackage

// File: rtl/l2_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// returned both one-hot and as an index.
module rr_pick
  import l2_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = rr_ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               valid
);

  int               cand_i;
  logic [PTR_W-1:0] cand;

  always_comb begin
    grant  = '0;
    idx    = '0;
    valid  = 1'b0;
    cand_i = 0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_i = (int'(ptr) + i) % NUM_REQ;
      cand   = PTR_W'(cand_i);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 request port among NUM_REQ L1 requesters.
// Optional per-requester grant/wait counters under L2_ARB_PERF_CNT_EN.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_REQ    = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]            req_addr,
  input  logic [NUM_REQ-1:0]                            req_read,
  input  logic [NUM_REQ-1:0]                            req_write,
  input  logic [NUM_REQ-1:0][BLOCK_SIZE*DATA_WIDTH-1:0] req_data_in,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]              req_data_out,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic                                          req_hit,
  output logic [ADDR_WIDTH-1:0]                         l2_cache_addr,
  output logic                                          l2_cache_read,
  output logic                                          l2_cache_write,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]              l2_cache_data_out,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]              l2_cache_data_in,
  input  logic                                          l2_cache_ready,
  input  logic                                          l2_cache_hit,
  output logic [1:0]                                    state_dbg
);

  localparam int BW = BLOCK_SIZE * DATA_WIDTH;
  localparam int PW = rr_ptr_width(NUM_REQ);

  arb_state_e        state, state_nx;
  logic [PW-1:0]     rr_ptr, grant_idx, pick_idx;
  logic [NUM_REQ-1:0] req_vec, pick_grant, grant_oh;
  logic              pick_valid, load, done;
  arb_op_e           grant_op;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [BW-1:0]     grant_data;

  assign req_vec = req_read | req_write;

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PW)) u_pick (
    .req   (req_vec),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign load = (state == ARB_IDLE) && pick_valid;
  assign done = (state == ARB_BUSY) && l2_cache_ready;

  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE:    if (pick_valid) state_nx = ARB_BUSY;
      ARB_BUSY:    if (l2_cache_ready) state_nx = ARB_RELEASE;
      ARB_RELEASE: state_nx = ARB_IDLE;
      default:     state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nx;
  end

  // Grant registers load only in IDLE, so requester changes during BUSY are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      grant_idx    <= '0;
      grant_oh     <= '0;
      grant_op     <= OP_READ;
      grant_addr   <= '0;
      grant_data   <= '0;
      req_ready    <= '0;
      req_hit      <= 1'b0;
      req_data_out <= '0;
    end else begin
      req_ready <= '0;
      if (load) begin
        grant_idx  <= pick_idx;
        grant_oh   <= pick_grant;
        grant_addr <= req_addr[pick_idx];
        grant_data <= req_data_in[pick_idx];
        grant_op   <= req_write[pick_idx] ? OP_WRITE : OP_READ;
      end
      if (done) begin
        req_ready    <= grant_oh;
        req_data_out <= l2_cache_data_in;
        req_hit      <= l2_cache_hit;
        rr_ptr       <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
      end
    end
  end

  // Request strobes decode from state so an async reset drops them at once.
  assign l2_cache_read     = (state == ARB_BUSY) && (grant_op == OP_READ);
  assign l2_cache_write    = (state == ARB_BUSY) && (grant_op == OP_WRITE);
  assign l2_cache_addr     = grant_addr;
  assign l2_cache_data_out = grant_data;
  assign state_dbg         = state;

`ifdef L2_ARB_PERF_CNT_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt;
  logic [NUM_REQ-1:0][31:0] wait_cnt;
  logic [NUM_REQ-1:0]       served;

  assign served = (state == ARB_IDLE) ? pick_grant : grant_oh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (grant_cnt[i] != '1)) grant_cnt[i] <= grant_cnt[i] + 32'd1;
        if (req_vec[i] && !served[i] && (wait_cnt[i] != '1)) wait_cnt[i] <= wait_cnt[i] + 32'd1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter with a behavioural L2 responder.
module tb_l2_port_arbiter;
  import l2_arb_pkg::*;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int BS = 16;
  localparam int NR = 2;
  localparam int BW = BS * DW;

  logic                   clk, rst;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0]          req_read, req_write;
  logic [NR-1:0][BW-1:0]  req_data_in;
  logic [BW-1:0]          req_data_out;
  logic [NR-1:0]          req_ready;
  logic                   req_hit;
  logic [AW-1:0]          l2_cache_addr;
  logic                   l2_cache_read, l2_cache_write;
  logic [BW-1:0]          l2_cache_data_out, l2_cache_data_in;
  logic                   l2_cache_ready, l2_cache_hit;
  logic [1:0]             state_dbg;

  l2_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .NUM_REQ(NR)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_addr          (req_addr),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_data_in       (req_data_in),
    .req_data_out      (req_data_out),
    .req_ready         (req_ready),
    .req_hit           (req_hit),
    .l2_cache_addr     (l2_cache_addr),
    .l2_cache_read     (l2_cache_read),
    .l2_cache_write    (l2_cache_write),
    .l2_cache_data_out (l2_cache_data_out),
    .l2_cache_data_in  (l2_cache_data_in),
    .l2_cache_ready    (l2_cache_ready),
    .l2_cache_hit      (l2_cache_hit),
    .state_dbg         (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // L2 model: byte lanes are addr[7:0]^0x85, hit is ~addr[4]
  function automatic logic [BW-1:0] resp_block(input logic [AW-1:0] a);
    logic [BW-1:0] b;
    for (int k = 0; k < BS; k++) b[k*DW +: DW] = a[7:0] ^ 8'h85;
    return b;
  endfunction

  function automatic logic resp_hit(input logic [AW-1:0] a);
    return ~a[4];
  endfunction

  int l2_lat   = 2;
  bit rand_lat = 0;
  int l2_cnt   = 0;
  int cur_lat  = 2;

  initial begin
    l2_cache_ready   = 1'b0;
    l2_cache_data_in = '0;
    l2_cache_hit     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || l2_cache_ready) begin
        l2_cache_ready = 1'b0;
        l2_cnt         = 0;
      end else if (l2_cache_read || l2_cache_write) begin
        if (l2_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : l2_lat;
        l2_cnt++;
        if (l2_cnt >= cur_lat) begin
          l2_cache_ready   = 1'b1;
          l2_cache_data_in = resp_block(l2_cache_addr);
          l2_cache_hit     = resp_hit(l2_cache_addr);
        end
      end
    end
  end

  // scoreboard: ready items {onehot, hit, data}; issue items {wr, addr, wdata}
  logic [130:0] exp_q[$];
  logic [139:0] iss_q[$];

  task automatic req_start(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [BW-1:0] d);
    req_addr[i]    = a;
    req_data_in[i] = d;
    req_read[i]    = rd;
    req_write[i]   = wr;
    iss_q.push_back({wr, a, d});
  endtask

  task automatic push_ready(input int i, input logic hit, input logic [BW-1:0] d);
    logic [1:0] oh;
    oh = 2'b01 << i;
    exp_q.push_back({oh, hit, d});
  endtask

  task automatic wait_done(input int i, input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        seen         = 1'b1;
        req_read[i]  = 1'b0;
        req_write[i] = 1'b0;
      end
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
  endtask

  int           cycle = 0, last_ready = 0, ready_seen = 0;
  bit           have_last = 0, prev_active = 0, active;
  logic [139:0] iss_item, held;
  logic [130:0] r_item;

  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      prev_active = 1'b0;
      have_last   = 1'b0;
    end else begin
      active = l2_cache_read | l2_cache_write;
      if (active && !prev_active) begin
        if (iss_q.size() == 0) check("issue_unexpected", active, 0);
        else begin
          iss_item = iss_q.pop_front();
          check("issue_op", {l2_cache_write, l2_cache_read}, iss_item[139] ? 2'b10 : 2'b01);
          check("issue_addr", l2_cache_addr, iss_item[138:128]);
          if (iss_item[139]) check("issue_wdata", l2_cache_data_out, iss_item[127:0]);
          if (have_last) check("release_gap", (cycle - last_ready) >= 2, 1);
        end
        held = {l2_cache_write, l2_cache_addr, l2_cache_data_out};
      end else if (active) begin
        check("issue_hold", {l2_cache_write, l2_cache_addr, l2_cache_data_out}, held);
      end
      if (|req_ready) begin
        ready_seen++;
        last_ready = cycle;
        have_last  = 1'b1;
        check("l2_drop", active, 0);
        if (exp_q.size() == 0) check("ready_unexpected", req_ready, 0);
        else begin
          r_item = exp_q.pop_front();
          check("ready_vec", req_ready, r_item[130:129]);
          check("ready_hit", req_hit, r_item[128]);
          check("ready_data", req_data_out, r_item[127:0]);
        end
      end
      prev_active = active;
    end
  end

  logic [BW-1:0] wb_blk;
  bit            seen_rd;
  int            target;

  initial begin
    rst         = 1'b1;
    req_addr    = '0;
    req_read    = '0;
    req_write   = '0;
    req_data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_state", state_dbg, ARB_IDLE);
    check("rst_rr_ptr", dut.rr_ptr, 0);
    check("rst_l2_req", {l2_cache_read, l2_cache_write, l2_cache_addr}, 0);
    check("rst_l2_data", l2_cache_data_out, 0);
    check("rst_resp", {req_ready, req_hit, req_data_out}, 0);
    rst = 1'b0;
    @(negedge clk);

    // simultaneous: r0 first, r1 only after RELEASE
    req_start(0, 1, 0, 11'h040, BW'($urandom));
    req_start(1, 1, 0, 11'h7F0, BW'($urandom));
    push_ready(0, resp_hit(11'h040), resp_block(11'h040));
    push_ready(1, resp_hit(11'h7F0), resp_block(11'h7F0));
    wait_done(0, "sim_r0");
    wait_done(1, "sim_r1");
    check("sim_rr_ptr", dut.rr_ptr, 0);

    // single read, 5-cycle L2
    l2_lat = 5;
    req_start(0, 1, 0, 11'h120, BW'($urandom));
    push_ready(0, 1'b1, {BS{8'hA5}});
    wait_done(0, "single");
    check("single_rr_ptr", dut.rr_ptr, 1);

    // write-back with bytes 0..15
    l2_lat = 3;
    for (int k = 0; k < BS; k++) wb_blk[k*DW +: DW] = 8'(k);
    req_start(1, 0, 1, 11'h3A0, wb_blk);
    push_ready(1, resp_hit(11'h3A0), resp_block(11'h3A0));
    wait_done(1, "wb");

    // read and write together: write wins
    l2_lat = 2;
    req_start(0, 1, 1, 11'h255, BW'($urandom));
    push_ready(0, resp_hit(11'h255), resp_block(11'h255));
    wait_done(0, "rdwr");
    check("rdwr_rr_ptr", dut.rr_ptr, 1);

    // reset while BUSY
    l2_lat  = 20;
    req_start(0, 1, 0, 11'h0AA, BW'($urandom));
    seen_rd = 1'b0;
    for (int c = 0; c < 10 && !seen_rd; c++) begin
      @(negedge clk);
      seen_rd = l2_cache_read;
    end
    check("mid_issue_seen", seen_rd, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_l2_read", l2_cache_read, 0);
    check("mid_rst_state", state_dbg, ARB_IDLE);
    check("mid_rst_ready", req_ready, 0);
    req_read = '0;
    exp_q.delete();
    iss_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("mid_rr_ptr", dut.rr_ptr, 0);
    repeat (4) @(negedge clk);
    check("mid_no_ready", req_ready, 0);
    l2_lat = 2;
    req_start(1, 1, 0, 11'h5C3, BW'($urandom));
    push_ready(1, resp_hit(11'h5C3), resp_block(11'h5C3));
    wait_done(1, "post_rst_r1");

    // fairness: both hold reads for 8 transactions
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    rand_lat       = 1'b1;
    req_addr[0]    = 11'h100;
    req_addr[1]    = 11'h210;
    req_data_in[0] = BW'($urandom);
    req_data_in[1] = BW'($urandom);
    for (int t = 0; t < 8; t++) begin
      iss_q.push_back({1'b0, req_addr[t % 2], req_data_in[t % 2]});
      push_ready(t % 2, resp_hit(req_addr[t % 2]), resp_block(req_addr[t % 2]));
    end
    target   = ready_seen + 8;
    req_read = 2'b11;
    for (int c = 0; c < 400 && req_read != 2'b00; c++) begin
      @(negedge clk);
      if (ready_seen >= target) req_read = 2'b00;
    end
    check("fair_done", ready_seen, target);
`ifdef L2_ARB_PERF_CNT_EN
    @(negedge clk);
    check("grant_cnt0", dut.grant_cnt[0], 4);
    check("grant_cnt1", dut.grant_cnt[1], 4);
`endif

    repeat (6) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("iss_q_empty", iss_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
